turn_scheduler: RTL and testbench
=================================

// Module: turn_scheduler
// PURPOSE
//  Shares the single mouse between the two snake players and paces the game.
//  Generates the periodic move tick, grants mouse control to one player per turn and
//  drives selected_player into direction_control.
//  Forwards click commands aligned to the move tick.
//  Sits between the mouse front-end and direction_control / snake position logic.
// PARAMETERS
//  TICK_CYCLES  8_125_000  clk cycles per move tick (>=2)
//  TURN_TICKS   40         max move ticks per turn before handover (>=1)
//  IDLE_TICKS   8          consecutive click-free ticks that force an early handover (>=1)
// PORTS
//  clk              in   1  system clock; the block uses this one clock only
//  rst_n            in   1  asynchronous, active-low reset
//  game_start       in   1  level; starts or restarts the game
//  game_over        in   1  level; collision or score end reported by game logic
//  mouse_left       in   1  raw left button level
//  mouse_right      in   1  raw right button level
//  selected_player  out  2  00=none (clears directions), 01=P1, 11=P2, 10=hold
//  move_tick        out  1  one-cycle pulse every TICK_CYCLES while playing
//  cmd_left         out  1  one-cycle pulse, coincident with move_tick
//  cmd_right        out  1  one-cycle pulse, coincident with move_tick
//  turn_count       out  8  completed turns, saturating at 255
// BEHAVIOUR
//  - Reset values: state IDLE, selected_player=00, move_tick=0, cmd_*=0,
//    turn_count=0, all counters 0, pending click cleared.
//  - All outputs are registered.
//  - States: IDLE, P1_TURN, HANDOVER, P2_TURN, OVER.
//    selected_player per state: IDLE=00; P1_TURN=01; P2_TURN=11; HANDOVER=10; OVER=10.
//  - IDLE: game_start=1 -> P1_TURN on the next edge.
//  - Any non-IDLE, non-OVER state: game_over=1 -> OVER (priority over all other transitions).
//  - OVER: game_start=1 -> IDLE; otherwise stay in OVER.
//    If game_over and game_start are both 1 in OVER, stay in OVER.
//  - Tick counter:
//    - Runs 0..TICK_CYCLES-1 in P1_TURN, HANDOVER and P2_TURN; held at 0 in IDLE and OVER.
//    - move_tick=1 in the cycle after the counter reaches TICK_CYCLES-1; the counter wraps to 0.
//    - Every state entry restarts the counter at 0.
//  - Click capture (turn states only):
//    - Rising edge = button 1 now and 0 in the previous cycle.
//    - Left and right edges in the same cycle are both dropped.
//    - The first valid edge in a tick window is latched; later edges in that window are ignored.
//    - At move_tick, the latched click appears as cmd_left/cmd_right for exactly that cycle,
//      then the latch clears.
//    - An edge in the cycle that produces move_tick belongs to the next window.
//  - Turn length:
//    - turn_ticks counts move ticks in the current turn.
//    - idle_ticks counts consecutive ticks with no command; it clears whenever cmd_* fires.
//    - On a move_tick where turn_ticks==TURN_TICKS-1 or idle_ticks==IDLE_TICKS-1
//      (with no command in that tick), go to HANDOVER.
//    - Entering HANDOVER increments turn_count (saturating).
//  - HANDOVER:
//    - Lasts exactly one tick period and emits move_tick but no cmd_*.
//    - Clicks in HANDOVER are discarded.
//    - Next state is the player who did not have the previous turn (P1->P2, P2->P1).
//  - Reset asserted mid-operation returns every register to its reset value immediately.
// STRUCTURE
//  - game_pkg: typedef enum sched_state_t {IDLE, P1_TURN, HANDOVER, P2_TURN, OVER};
//    localparams SEL_NONE=2'b00, SEL_P1=2'b01, SEL_HOLD=2'b10, SEL_P2=2'b11.
//  - Sub-module tick_divider (TICK_CYCLES): inputs clk, rst_n, run; output tick pulse.
//    run=0 forces the count to 0.
//  - FSM, click latch and turn counters live in turn_scheduler.
// TESTING  (TICK_CYCLES=4, TURN_TICKS=3, IDLE_TICKS=2)
//  1. Reset, then game_start pulse -> selected_player 00 then 01;
//     move_tick every 4 cycles; cmd_* stay 0.
//  2. Right click 1 cycle after a tick -> cmd_right=1 only with the next move_tick;
//     a second click in the same window produces no extra cmd.
//  3. Left and right rise together -> no cmd; idle_ticks still advances.
//  4. No clicks -> after 2 ticks HANDOVER (sel=10, turn_count=1);
//     4 cycles later sel=11; after 2 more ticks back to 01 with turn_count=2.
//  5. Click every tick -> handover after exactly 3 ticks.
//  6. game_over mid-turn -> sel=10, ticks stop; then game_start -> sel=00, then 01;
//     rst_n low mid-turn -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the two-player turn scheduler: FSM states and the
// selected_player encodings seen by direction_control.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1_TURN,
    HANDOVER,
    P2_TURN,
    OVER
  } sched_state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;
  localparam logic [1:0] SEL_P2   = 2'b11;

  function automatic logic [1:0] sel_of(sched_state_t s);
    case (s)
      IDLE:    return SEL_NONE;
      P1_TURN: return SEL_P1;
      P2_TURN: return SEL_P2;
      default: return SEL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running move-tick divider. The tick strobe is combinational and fires in
// the last cycle of each window; run=0 parks the count at 0.
module tick_divider #(
  parameter int TICK_CYCLES = 8_125_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (!run || tick)   cnt_q <= '0;
    else                     cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/turn_scheduler.sv
// Shares one mouse between two snake players: paces moves with a periodic tick,
// hands control over on turn/idle limits and forwards clicks aligned to the tick.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = 8_125_000,
  parameter int TURN_TICKS  = 40,
  parameter int IDLE_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       mouse_left,
  input  logic       mouse_right,
  output logic [1:0] selected_player,
  output logic       move_tick,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic [7:0] turn_count
);

  localparam int TW = $clog2(TURN_TICKS + 1);
  localparam int IW = $clog2(IDLE_TICKS + 1);

  sched_state_t  state_q, state_d;
  logic [1:0]    pend_q, pend_d;   // {right, left}; at most one bit set
  logic [TW-1:0] turn_q, turn_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          prev_l_q, prev_r_q, last_p2_q;
  logic [1:0]    sel_q;
  logic          tick_q, cl_q, cr_q;
  logic [7:0]    tc_q;

  logic in_turn, playing, strobe, l_rise, r_rise, enter_ho;

  assign in_turn = (state_q == P1_TURN) || (state_q == P2_TURN);
  assign playing = in_turn || (state_q == HANDOVER);
  assign l_rise  = mouse_left  & ~prev_l_q;
  assign r_rise  = mouse_right & ~prev_r_q;

  // game_over always leaves the playing states, so gating it here restarts the
  // count on every state entry and suppresses a tick on the way out.
  tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (playing && !game_over),
    .tick (strobe)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (game_start) state_d = P1_TURN;
      OVER: if (game_start && !game_over) state_d = IDLE;
      P1_TURN, P2_TURN: begin
        if (game_over) state_d = OVER;
        else if (strobe && ((turn_q == TW'(TURN_TICKS - 1)) ||
                            (pend_q == 2'b00 && idle_q == IW'(IDLE_TICKS - 1))))
          state_d = HANDOVER;
      end
      HANDOVER: begin
        if (game_over)   state_d = OVER;
        else if (strobe) state_d = last_p2_q ? P1_TURN : P2_TURN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_ho = (state_d == HANDOVER) && (state_q != HANDOVER);

  // A click seen in the strobe cycle is kept for the following window.
  always_comb begin
    pend_d = pend_q;
    turn_d = turn_q;
    idle_d = idle_q;
    if (state_d != state_q) begin
      pend_d = '0;
      turn_d = '0;
      idle_d = '0;
    end else if (in_turn) begin
      if (strobe) begin
        pend_d = '0;
        turn_d = turn_q + 1'b1;
        idle_d = (pend_q != 2'b00) ? '0 : idle_q + 1'b1;
      end
      if (pend_d == 2'b00 && (l_rise ^ r_rise)) pend_d = {r_rise, l_rise};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      turn_q    <= '0;
      idle_q    <= '0;
      prev_l_q  <= 1'b0;
      prev_r_q  <= 1'b0;
      last_p2_q <= 1'b0;
      sel_q     <= SEL_NONE;
      tick_q    <= 1'b0;
      cl_q      <= 1'b0;
      cr_q      <= 1'b0;
      tc_q      <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      turn_q   <= turn_d;
      idle_q   <= idle_d;
      prev_l_q <= mouse_left;
      prev_r_q <= mouse_right;
      sel_q    <= sel_of(state_d);
      tick_q   <= strobe;
      cl_q     <= strobe & pend_q[0];
      cr_q     <= strobe & pend_q[1];
      if (enter_ho) begin
        last_p2_q <= (state_q == P2_TURN);
        if (tc_q != 8'hFF) tc_q <= tc_q + 1'b1;
      end
    end
  end

  assign selected_player = sel_q;
  assign move_tick       = tick_q;
  assign cmd_left        = cl_q;
  assign cmd_right       = cr_q;
  assign turn_count      = tc_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: explicit per-cycle vector table, hand-written corner
// sequences, then randomized traffic compared against a window/turn-level model.
module tb_turn_scheduler;

  localparam int TC = 4;
  localparam int TT = 3;
  localparam int IT = 2;

  localparam int M_IDLE = 0, M_P1 = 1, M_HO = 2, M_P2 = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0, game_over = 1'b0;
  logic       mouse_left = 1'b0, mouse_right = 1'b0;
  logic [1:0] selected_player;
  logic       move_tick, cmd_left, cmd_right;
  logic [7:0] turn_count;

  turn_scheduler #(.TICK_CYCLES(TC), .TURN_TICKS(TT), .IDLE_TICKS(IT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_start     (game_start),
    .game_over      (game_over),
    .mouse_left     (mouse_left),
    .mouse_right    (mouse_right),
    .selected_player(selected_player),
    .move_tick      (move_tick),
    .cmd_left       (cmd_left),
    .cmd_right      (cmd_right),
    .turn_count     (turn_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: game phase, position inside the current tick window,
  // pending click (0 none, 1 left, 2 right), per-turn tallies.
  int m_st, m_pos, m_pend, m_tt, m_it, m_tc, m_last2;
  bit m_pl, m_pr;
  int e_sel;
  bit e_tick, e_cl, e_cr;

  typedef struct {
    bit         gs, ml, mr;
    logic [1:0] sel;
    bit         tick, cl, cr;
    logic [7:0] tc;
  } vec_t;
  vec_t tbl[41];

  bit rl = 1'b0, rr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pos = 0; m_pend = 0; m_tt = 0; m_it = 0; m_tc = 0; m_last2 = 0;
    m_pl = 0; m_pr = 0; e_sel = 0; e_tick = 0; e_cl = 0; e_cr = 0;
  endtask

  task automatic model_step(input bit gs, input bit go, input bit ml, input bit mr);
    int nxt, click;
    bit playing, strobe, le, re;
    playing = (m_st == M_P1) || (m_st == M_HO) || (m_st == M_P2);
    strobe  = playing && !go && (m_pos == TC - 1);
    le = ml && !m_pl;
    re = mr && !m_pr;
    click = (le && !re) ? 1 : (re && !le) ? 2 : 0;
    nxt = m_st;
    if (m_st == M_IDLE) begin
      if (gs) nxt = M_P1;
    end else if (m_st == M_OVER) begin
      if (gs && !go) nxt = M_IDLE;
    end else if (go) nxt = M_OVER;
    else if (strobe) begin
      if (m_st == M_HO) nxt = (m_last2 != 0) ? M_P1 : M_P2;
      else if (m_tt == TT - 1 || (m_pend == 0 && m_it == IT - 1)) nxt = M_HO;
    end
    e_tick = strobe;
    e_cl   = strobe && m_pend == 1;
    e_cr   = strobe && m_pend == 2;
    if (nxt != m_st) begin
      if (nxt == M_HO) begin
        m_last2 = (m_st == M_P2) ? 1 : 0;
        if (m_tc < 255) m_tc++;
      end
      m_pos = 0; m_pend = 0; m_tt = 0; m_it = 0;
    end else if (playing) begin
      m_pos = (m_pos + 1) % TC;
      if (m_st != M_HO) begin
        if (strobe) begin
          m_tt++;
          m_it = (m_pend != 0) ? 0 : m_it + 1;
          m_pend = 0;
        end
        if (m_pend == 0) m_pend = click;
      end
    end
    m_st = nxt;
    m_pl = ml; m_pr = mr;
    e_sel = (m_st == M_IDLE) ? 0 : (m_st == M_P1) ? 1 : (m_st == M_P2) ? 3 : 2;
  endtask

  task automatic step(input bit gs, input bit go, input bit ml, input bit mr);
    @(negedge clk);
    game_start = gs; game_over = go; mouse_left = ml; mouse_right = mr;
    @(posedge clk);
    #1;
    model_step(gs, go, ml, mr);
    chk("model_sel",  32'(selected_player), 32'(e_sel));
    chk("model_tick", 32'(move_tick),       32'(e_tick));
    chk("model_cl",   32'(cmd_left),        32'(e_cl));
    chk("model_cr",   32'(cmd_right),       32'(e_cr));
    chk("model_tc",   32'(turn_count),      32'(m_tc));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_sel"},  32'(selected_player), 0);
    chk({nm, "_tick"}, 32'(move_tick), 0);
    chk({nm, "_cl"},   32'(cmd_left), 0);
    chk({nm, "_cr"},   32'(cmd_right), 0);
    chk({nm, "_tc"},   32'(turn_count), 0);
  endtask

  initial begin
    // Hand-derived timeline (TC=4,TT=3,IDLE=2): ticks every 4 rows from row 4.
    for (int i = 0; i < 41; i++) begin
      tbl[i].gs = 0; tbl[i].ml = 0; tbl[i].mr = 0;
      tbl[i].tick = (i > 0) && (i % 4 == 0);
      tbl[i].cl = 0; tbl[i].cr = 0;
      tbl[i].sel = (i < 8) ? 2'b01 : (i < 12) ? 2'b10 : (i < 20) ? 2'b11 :
                   (i < 24) ? 2'b10 : (i < 36) ? 2'b01 : (i < 40) ? 2'b10 : 2'b11;
      tbl[i].tc  = (i < 8) ? 8'd0 : (i < 20) ? 8'd1 : (i < 36) ? 8'd2 : 8'd3;
    end
    tbl[0].gs  = 1;
    tbl[25].mr = 1;   // click one cycle after a tick
    tbl[27].mr = 1;   // second click in the same window: ignored
    tbl[28].cr = 1;
    tbl[29].ml = 1;   // simultaneous rise: dropped
    tbl[29].mr = 1;

    model_reset();
    #23;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 41; i++) begin
      step(tbl[i].gs, 1'b0, tbl[i].ml, tbl[i].mr);
      chk($sformatf("tbl%0d_sel", i),  32'(selected_player), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_tick", i), 32'(move_tick),       32'(tbl[i].tick));
      chk($sformatf("tbl%0d_cl", i),   32'(cmd_left),        32'(tbl[i].cl));
      chk($sformatf("tbl%0d_cr", i),   32'(cmd_right),       32'(tbl[i].cr));
      chk($sformatf("tbl%0d_tc", i),   32'(turn_count),      32'(tbl[i].tc));
    end

    // game_over mid-turn, then restart via OVER -> IDLE -> P1
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("over_sel", 32'(selected_player), 2);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      chk("over_tick", 32'(move_tick), 0);
      chk("over_hold", 32'(selected_player), 2);
    end
    step(1, 1, 0, 0);
    chk("over_both_sel", 32'(selected_player), 2);
    step(1, 0, 0, 0);
    chk("restart_idle", 32'(selected_player), 0);
    step(1, 0, 0, 0);
    chk("restart_p1", 32'(selected_player), 1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);

    // asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    game_start = 0; mouse_left = 0; mouse_right = 0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();

    // click in every window: turn ends on the turn limit after exactly 3 ticks
    step(1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 1'b0, (k % 4 == 1));
      if (k % 4 == 0) chk($sformatf("busy_cr%0d", k), 32'(cmd_right), 1);
      chk($sformatf("busy_sel%0d", k), 32'(selected_player), (k < 12) ? 1 : 2);
    end
    chk("busy_tc", 32'(turn_count), 1);

    // randomized traffic; long enough to drive turn_count into saturation
    for (int i = 0; i < 9000; i++) begin
      if ($urandom_range(2, 0) == 0) rl = ~rl;
      if ($urandom_range(2, 0) == 0) rr = ~rr;
      if ($urandom_range(29, 0) == 0) begin rl = 1; rr = 1; end
      step($urandom_range(19, 0) == 0, $urandom_range(499, 0) == 0, rl, rr);
    end
    chk("sat_tc", 32'(turn_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
